// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_pkg
//  Description : Shared constants, state encoding and helpers for the SPI
//                responder and its SPI master counterpart.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

    // Frame width and idle pattern shared with the SPI master.
    localparam int                        SPI_DATA_WIDTH = 8;
    localparam logic [SPI_DATA_WIDTH-1:0] SPI_IDLE_WORD  = '1;

    // Link state: IDLE while the synchronized select is high.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // Width of a counter that must hold the values 0 .. w-1.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage : spi_slave_pkg
`default_nettype wire

// File: rtl/spi_slave_sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : N-stage single-bit synchronizer with a configurable reset
//                value, used to bring the asynchronous SPI pins into clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the pin value through the flop chain; bit 0 is the capture flop.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : SPI mode-0 responder, MSB first. Oversamples sck/ss_n/mosi
//                in the clk domain, strobes out received words and shifts
//                out words taken from a single-entry ready/valid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  sck,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_t,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun
);

    localparam int                  c_CNT_W = cnt_width(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(DATA_WIDTH - 1);

    // Synchronized pins
    logic w_sck_s;
    logic w_ss_s;
    logic w_mosi_s;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk  (clk),
        .nrst (nrst),
        .i_d  (sck),
        .o_q  (w_sck_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk  (clk),
        .nrst (nrst),
        .i_d  (ss_n),
        .o_q  (w_ss_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk  (clk),
        .nrst (nrst),
        .i_d  (mosi),
        .o_q  (w_mosi_s)
    );

    // State. The transmit shifter holds only the bits after the current MSB;
    // the MSB itself lives in the registered miso flop.
    spi_state_e              r_state;
    logic                    r_sck_d;
    logic                    r_ss_d;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-2:0]   r_rx_shift;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic                    r_rx_valid;
    logic [DATA_WIDTH-2:0]   r_tx_shift;
    logic [DATA_WIDTH-1:0]   r_tx_buf;
    logic                    r_tx_full;
    logic                    r_tx_underrun;
    logic                    r_miso;

    // Edge strobes and derived control
    logic                    w_sck_rise;
    logic                    w_sck_fall;
    logic                    w_ss_fall;
    logic                    w_ss_rise;
    logic                    w_active;
    logic                    w_bit_shift;
    logic                    w_load;
    logic                    w_tx_wr;
    logic [DATA_WIDTH-1:0]   w_next_word;
    logic [DATA_WIDTH-1:0]   w_rx_next;

    assign w_sck_rise  =  w_sck_s & ~r_sck_d;
    assign w_sck_fall  = ~w_sck_s &  r_sck_d;
    assign w_ss_fall   = ~w_ss_s  &  r_ss_d;
    assign w_ss_rise   =  w_ss_s  & ~r_ss_d;

    // Deselect wins over any sck edge landing in the same cycle.
    assign w_active    = (r_state == ST_ACTIVE) & ~w_ss_rise;
    assign w_bit_shift = w_active & w_sck_fall & (r_bit_cnt != '0);

    // A word is loaded at select, and on the sck fall right after a word
    // completes so that back-to-back words flow under one select.
    assign w_load      = w_ss_fall | (w_active & w_sck_fall & (r_bit_cnt == '0));
    assign w_tx_wr     = tx_valid & ~r_tx_full;
    assign w_next_word = r_tx_full ? r_tx_buf : IDLE_WORD;
    assign w_rx_next   = {r_rx_shift, w_mosi_s};

    // Link FSM, receive shifter, transmit shifter and TX buffer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= ST_IDLE;
            r_sck_d       <= 1'b0;
            r_ss_d        <= 1'b1;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_shift    <= '0;
            r_tx_buf      <= '0;
            r_tx_full     <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_miso        <= 1'b1;
        end else begin
            r_sck_d       <= w_sck_s;
            r_ss_d        <= w_ss_s;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;

            // Receive side; a select edge suppresses sck edges in its cycle.
            if (w_ss_rise) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
            end else if (w_ss_fall) begin
                r_state   <= ST_ACTIVE;
            end else if (r_state == ST_ACTIVE && w_sck_rise) begin
                r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
                if (r_bit_cnt == c_LAST) begin
                    r_bit_cnt  <= '0;
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                end
            end

            // Transmit side; a load sees the buffer as it was before any
            // write in the same cycle, and that write refills it.
            if (w_load) begin
                r_miso        <= w_next_word[DATA_WIDTH-1];
                r_tx_shift    <= w_next_word[DATA_WIDTH-2:0];
                r_tx_underrun <= ~r_tx_full;
                r_tx_full     <= w_tx_wr;
                if (w_tx_wr) begin
                    r_tx_buf  <= tx_data;
                end
            end else begin
                if (w_bit_shift) begin
                    r_miso     <= r_tx_shift[DATA_WIDTH-2];
                    r_tx_shift <= {r_tx_shift[DATA_WIDTH-3:0], 1'b0};
                end
                if (w_tx_wr) begin
                    r_tx_buf  <= tx_data;
                    r_tx_full <= 1'b1;
                end
            end
        end
    end

    assign miso        = r_miso;
    assign miso_t      = w_ss_s;
    assign tx_ready    = ~r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;

endmodule : spi_slave
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Self-checking bench for spi_slave: a table of single-word
//                frames plus hand-written multi-cycle corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int W    = 8;
    localparam int SS   = 2;   // SYNC_STAGES of the DUT
    localparam int HALF = 8;   // sck half period in clk cycles

    logic         clk      = 1'b0;
    logic         nrst     = 1'b0;
    logic         sck      = 1'b0;
    logic         ss_n     = 1'b1;
    logic         mosi     = 1'b0;
    logic [W-1:0] tx_data  = '0;
    logic         tx_valid = 1'b0;
    logic         miso;
    logic         miso_t;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         tx_underrun;

    spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(SS), .IDLE_WORD(8'hFF)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .sck         (sck),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_t      (miso_t),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int und_cnt = 0;
    logic [W-1:0] rx_log[$];

    // Strobe monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt = rx_cnt + 1;
            rx_log.push_back(rx_data);
        end
        if (tx_underrun) begin
            und_cnt = und_cnt + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push one word into the TX buffer once it is ready (bounded wait).
    task automatic bus_write(input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Shift nbits of one word; sck is left high after the last bit.
    // Optionally writes wr_d into the TX buffer during bit 3.
    task automatic spi_bits(input logic [W-1:0] mo, input int nbits,
                            input bit do_wr, input logic [W-1:0] wr_d,
                            output logic [W-1:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            sck  = 1'b0;
            mosi = mo[W-1-i];
            if (do_wr && i == 3) begin
                tx_data  = wr_d;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (HALF-1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sck = 1'b1;
            mi  = {mi[W-2:0], miso};
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic do_select();
        @(negedge clk);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // Deselect while sck is still high, then return sck to idle low.
    task automatic do_deselect();
        ss_n = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    typedef struct {
        logic         has_tx;
        logic [W-1:0] tx;
        logic [W-1:0] mo;
        logic [W-1:0] exp_mi;
        logic [W-1:0] exp_rx;
        int           exp_und;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [W-1:0] m1, m2;
        int r0, u0, q0;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 1};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
        vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_miso",     {31'd0, miso},        32'd1);
        check("rst_miso_t",   {31'd0, miso_t},      32'd1);
        check("rst_tx_ready", {31'd0, tx_ready},    32'd1);
        check("rst_rx_data",  {24'd0, rx_data},     32'd0);
        check("rst_rx_valid", {31'd0, rx_valid},    32'd0);
        check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        // Single-word frames from the table
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].has_tx) bus_write(vecs[i].tx);
            r0 = rx_cnt;
            u0 = und_cnt;
            do_select();
            spi_bits(vecs[i].mo, W, 1'b0, '0, m1);
            do_deselect();
            check($sformatf("v%0d_miso_word", i), {24'd0, m1},      {24'd0, vecs[i].exp_mi});
            check($sformatf("v%0d_rx_data", i),   {24'd0, rx_data}, {24'd0, vecs[i].exp_rx});
            check($sformatf("v%0d_rx_pulses", i), rx_cnt - r0,      32'd1);
            check($sformatf("v%0d_underrun", i),  und_cnt - u0,     vecs[i].exp_und);
            check($sformatf("v%0d_tx_ready", i),  {31'd0, tx_ready}, 32'd1);
        end

        // Back-to-back words under one select
        bus_write(8'h11);
        r0 = rx_cnt;
        u0 = und_cnt;
        q0 = rx_log.size();
        do_select();
        spi_bits(8'h01, W, 1'b1, 8'h22, m1);
        spi_bits(8'h02, W, 1'b0, '0, m2);
        do_deselect();
        check("b2b_miso_w0",  {24'd0, m1}, 32'h11);
        check("b2b_miso_w1",  {24'd0, m2}, 32'h22);
        check("b2b_rx_pulses", rx_cnt - r0, 32'd2);
        check("b2b_underrun",  und_cnt - u0, 32'd0);
        if (rx_log.size() >= q0 + 2) begin
            check("b2b_rx_w0", {24'd0, rx_log[q0]},   32'h01);
            check("b2b_rx_w1", {24'd0, rx_log[q0+1]}, 32'h02);
        end

        // Abort after 5 bits, then a clean word
        r0 = rx_cnt;
        do_select();
        spi_bits(8'hF0, 5, 1'b0, '0, m1);
        do_deselect();
        check("abort_no_rx",   rx_cnt - r0, 32'd0);
        check("abort_bit_cnt", 32'(dut.r_bit_cnt), 32'd0);
        r0 = rx_cnt;
        do_select();
        spi_bits(8'h5A, W, 1'b0, '0, m1);
        do_deselect();
        check("post_abort_rx",     {24'd0, rx_data}, 32'h5A);
        check("post_abort_pulses", rx_cnt - r0,      32'd1);
        check("post_abort_miso",   {24'd0, m1},      32'hFF);

        // Write landing in the same cycle as the select load
        u0 = und_cnt;
        @(negedge clk);
        ss_n = 1'b0;
        repeat (SS) @(negedge clk);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("same_cyc_tx_ready", {31'd0, tx_ready}, 32'd0);
        repeat (HALF) @(negedge clk);
        spi_bits(8'h33, W, 1'b0, '0, m1);
        spi_bits(8'hCC, W, 1'b0, '0, m2);
        do_deselect();
        check("same_cyc_miso_w0",  {24'd0, m1},      32'hFF);
        check("same_cyc_miso_w1",  {24'd0, m2},      32'hC3);
        check("same_cyc_underrun", und_cnt - u0,     32'd1);
        check("same_cyc_rx",       {24'd0, rx_data}, 32'hCC);

        // Reset in the middle of a frame
        bus_write(8'hAA);
        r0 = rx_cnt;
        do_select();
        spi_bits(8'hFF, 3, 1'b0, '0, m1);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        check("midrst_miso",     {31'd0, miso},     32'd1);
        check("midrst_miso_t",   {31'd0, miso_t},   32'd1);
        check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_bit_cnt",  32'(dut.r_bit_cnt), 32'd0);
        ss_n = 1'b1;
        sck  = 1'b0;
        repeat (4) @(negedge clk);
        nrst = 1'b1;
        repeat (2*HALF) @(negedge clk);
        check("midrst_no_rx", rx_cnt - r0, 32'd0);
        do_select();
        spi_bits(8'h96, W, 1'b0, '0, m1);
        do_deselect();
        check("postrst_miso", {24'd0, m1},      32'hFF);
        check("postrst_rx",   {24'd0, rx_data}, 32'h96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spi_slave
`default_nettype wire
